// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 max-pooling window interface: default operand width,
// feeder FSM encodings and the window field order agreed with the pooling unit.
package pool_pkg;

    localparam int POOL_DATA_W = 5;

    typedef enum logic [1:0] {
        S_TOP  = 2'd0,
        S_BOT  = 2'd1,
        S_LAST = 2'd2
    } pool_state_e;

    // Window field order: top-left, top-right, bottom-left, bottom-right
    localparam int WIN_TL = 0;
    localparam int WIN_TR = 1;
    localparam int WIN_BL = 2;
    localparam int WIN_BR = 3;
    localparam int WIN_N  = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// One-row pixel store for the window feeder: single write port, two asynchronous
// read ports so both top-row pixels of a window are available in the same cycle.
module pool_line_buffer
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 5,
    parameter int ADDR_W = 2
)(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b
);

    logic [DATA_W-1:0] mem_rd [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [DATA_W-1:0] cell_reg;

            always_ff @(posedge clk) begin
                if (we && (wr_addr == ADDR_W'(gi))) begin
                    cell_reg <= wr_data;
                end
            end

            assign mem_rd[gi] = cell_reg;
        end
    endgenerate

    assign rd_data_a = mem_rd[rd_addr_a];
    assign rd_data_b = mem_rd[rd_addr_b];

endmodule

// File: rtl/pool_window_feeder.sv
// Turns a raster pixel stream into non-overlapping 2x2 windows (stride 2) for the pooling unit.
// Optional POOL_FEEDER_IDX_EN adds the pooled-output coordinate (win_row, win_col) of each window.
module pool_window_feeder
    import pool_pkg::*;
#(
    parameter int DATA_W = POOL_DATA_W,
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_W-1:0]             pix_in,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    output logic [DATA_W-1:0]             win_tl,
    output logic [DATA_W-1:0]             win_tr,
    output logic [DATA_W-1:0]             win_bl,
    output logic [DATA_W-1:0]             win_br,
    output logic                          win_valid,
    input  logic                          win_ready,
`ifdef POOL_FEEDER_IDX_EN
    output logic [idx_w(IMG_H/2)-1:0]     win_row,
    output logic [idx_w(IMG_W/2)-1:0]     win_col,
`endif
    output logic                          frame_done
);

    localparam int COL_W = idx_w(IMG_W);
    localparam int ROW_W = idx_w(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || IMG_W < 2 || IMG_H < 2) begin : g_bad_geometry
        $fatal(1, "pool_window_feeder: IMG_W and IMG_H must be even and >= 2");
    end

    pool_state_e       state_reg;
    logic [COL_W-1:0]  col_reg;
    logic [ROW_W-1:0]  row_reg;
    logic [DATA_W-1:0] hold_reg;
    logic              win_valid_reg;
    logic              frame_done_reg;
    logic [DATA_W-1:0] win_reg  [WIN_N];
    logic [DATA_W-1:0] win_next [WIN_N];

    logic              accept;
    logic              load;
    logic              handshake;
    logic              buf_we;
    logic [COL_W-1:0]  left_addr;
    logic [DATA_W-1:0] lb_left;
    logic [DATA_W-1:0] lb_right;

    // The last row stalls input until its window leaves, so frames never interleave
    assign pix_ready = (state_reg != S_LAST) && (!win_valid_reg || win_ready);
    assign accept    = pix_valid && pix_ready;
    assign handshake = win_valid_reg && win_ready;
    assign load      = accept && (state_reg == S_BOT) && col_reg[0];
    assign buf_we    = accept && (state_reg == S_TOP);
    assign left_addr = col_reg - 1'b1;

    pool_line_buffer #(
        .DEPTH  (IMG_W),
        .DATA_W (DATA_W),
        .ADDR_W (COL_W)
    ) u_line_buffer (
        .clk       (clk),
        .we        (buf_we),
        .wr_addr   (col_reg),
        .wr_data   (pix_in),
        .rd_addr_a (left_addr),
        .rd_data_a (lb_left),
        .rd_addr_b (col_reg),
        .rd_data_b (lb_right)
    );

    always_comb begin
        win_next[WIN_TL] = lb_left;
        win_next[WIN_TR] = lb_right;
        win_next[WIN_BL] = hold_reg;
        win_next[WIN_BR] = pix_in;
    end

    generate
        for (genvar gi = 0; gi < WIN_N; gi++) begin : g_win
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    win_reg[gi] <= '0;
                end else if (load) begin
                    win_reg[gi] <= win_next[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= S_TOP;
            col_reg        <= '0;
            row_reg        <= '0;
            hold_reg       <= '0;
            win_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            // A load in the same cycle as a handshake keeps the output valid back-to-back
            if (load) begin
                win_valid_reg <= 1'b1;
            end else if (handshake) begin
                win_valid_reg <= 1'b0;
            end

            case (state_reg)
                S_TOP: begin
                    if (accept) begin
                        if (col_reg == COL_LAST) begin
                            col_reg   <= '0;
                            row_reg   <= row_reg + 1'b1;
                            state_reg <= S_BOT;
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end
                    end
                end
                S_BOT: begin
                    if (accept) begin
                        if (!col_reg[0]) begin
                            hold_reg <= pix_in;
                        end
                        if (col_reg == COL_LAST) begin
                            col_reg <= '0;
                            if (row_reg == ROW_LAST) begin
                                state_reg <= S_LAST;
                            end else begin
                                row_reg   <= row_reg + 1'b1;
                                state_reg <= S_TOP;
                            end
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end
                    end
                end
                S_LAST: begin
                    if (handshake) begin
                        frame_done_reg <= 1'b1;
                        row_reg        <= '0;
                        state_reg      <= S_TOP;
                    end
                end
                default: state_reg <= S_TOP;
            endcase
        end
    end

`ifdef POOL_FEEDER_IDX_EN
    localparam int RI_W = idx_w(IMG_H/2);
    localparam int CI_W = idx_w(IMG_W/2);
    logic [RI_W-1:0] win_row_reg;
    logic [CI_W-1:0] win_col_reg;

    // Loaded on the bottom-right pixel, so row/col are odd and halving gives the pooled index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_row_reg <= '0;
            win_col_reg <= '0;
        end else if (load) begin
            win_row_reg <= RI_W'(row_reg >> 1);
            win_col_reg <= CI_W'(col_reg >> 1);
        end
    end

    assign win_row = win_row_reg;
    assign win_col = win_col_reg;
`endif

    assign win_tl     = win_reg[WIN_TL];
    assign win_tr     = win_reg[WIN_TR];
    assign win_bl     = win_reg[WIN_BL];
    assign win_br     = win_reg[WIN_BR];
    assign win_valid  = win_valid_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_pool_window_feeder.sv
// Scoreboard bench for pool_window_feeder (4x4, 5-bit): stimulus pushes expected windows,
// a negedge monitor pops and compares on each window handshake.
module tb_pool_window_feeder;

    localparam int DW = 5;

    typedef struct packed {
        logic [DW-1:0] tl;
        logic [DW-1:0] tr;
        logic [DW-1:0] bl;
        logic [DW-1:0] br;
        logic          last;
        logic          r;
        logic          c;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] pix_in = '0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [DW-1:0] win_tl, win_tr, win_bl, win_br;
    logic          win_valid;
    logic          win_ready = 1'b1;
    logic          frame_done;
`ifdef POOL_FEEDER_IDX_EN
    logic [0:0]    win_row;
    logic [0:0]    win_col;
`endif

    always #5 clk = ~clk;

    pool_window_feeder #(
        .DATA_W (DW),
        .IMG_W  (4),
        .IMG_H  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .win_tl     (win_tl),
        .win_tr     (win_tr),
        .win_bl     (win_bl),
        .win_br     (win_br),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
`ifdef POOL_FEEDER_IDX_EN
        .win_row    (win_row),
        .win_col    (win_col),
`endif
        .frame_done (frame_done)
    );

    exp_t           q[$];
    exp_t           mon_e;
    int             total = 0;
    int             bad = 0;
    int             hs_count = 0;
    int             fd_count = 0;
    logic           fd_expect = 1'b0;
    logic           prev_stall = 1'b0;
    logic [4*DW-1:0] prev_win = '0;

    // Hand-computed windows of a 4x4 frame holding pixels 0..15 in raster order
    int exp1 [16] = '{0, 1, 4, 5,   2, 3, 6, 7,   8, 9, 12, 13,   10, 11, 14, 15};

    always @(negedge clk) begin
        if (!rst_n) begin
            fd_expect  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            total++;
            if (frame_done !== fd_expect) begin
                bad++;
                $display("FAIL frame_done: got %b want %b at %0t", frame_done, fd_expect, $time);
            end
            if (frame_done === 1'b1) fd_count++;
            fd_expect = 1'b0;

            if (prev_stall) begin
                total++;
                if ({win_valid, win_tl, win_tr, win_bl, win_br} !== {1'b1, prev_win}) begin
                    bad++;
                    $display("FAIL hold_stable: got v=%b %h want v=1 %h at %0t",
                             win_valid, {win_tl, win_tr, win_bl, win_br}, prev_win, $time);
                end
            end

            if (win_valid === 1'b1 && win_ready === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_window: got {%0d,%0d,%0d,%0d} want none at %0t",
                             win_tl, win_tr, win_bl, win_br, $time);
                end else begin
                    mon_e = q.pop_front();
                    if ({win_tl, win_tr, win_bl, win_br} !== {mon_e.tl, mon_e.tr, mon_e.bl, mon_e.br}) begin
                        bad++;
                        $display("FAIL window%0d: got {%0d,%0d,%0d,%0d} want {%0d,%0d,%0d,%0d}",
                                 hs_count, win_tl, win_tr, win_bl, win_br,
                                 mon_e.tl, mon_e.tr, mon_e.bl, mon_e.br);
                    end
`ifdef POOL_FEEDER_IDX_EN
                    total++;
                    if ({win_row, win_col} !== {mon_e.r, mon_e.c}) begin
                        bad++;
                        $display("FAIL win_idx%0d: got (%0d,%0d) want (%0d,%0d)",
                                 hs_count, win_row, win_col, mon_e.r, mon_e.c);
                    end
`endif
                    fd_expect = mon_e.last;
                end
                hs_count++;
            end
            prev_stall = (win_valid === 1'b1) && (win_ready === 1'b0);
            prev_win   = {win_tl, win_tr, win_bl, win_br};
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic push_win(input int tl, input int tr, input int bl, input int br,
                            input logic last, input logic r, input logic c);
        exp_t e;
        e.tl = DW'(tl); e.tr = DW'(tr); e.bl = DW'(bl); e.br = DW'(br);
        e.last = last; e.r = r; e.c = c;
        q.push_back(e);
    endtask

    task automatic push_frame(input int base, input int nwin);
        for (int k = 0; k < nwin; k++) begin
            push_win(base + exp1[4*k], base + exp1[4*k+1], base + exp1[4*k+2], base + exp1[4*k+3],
                     (k == 3), k[1], k[0]);
        end
    endtask

    task automatic send(input int v);
        int n = 0;
        pix_in    = DW'(v);
        pix_valid = 1'b1;
        @(negedge clk);
        while (pix_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (pix_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL pix_accept_timeout: got ready=%b want 1 for pixel %0d", pix_ready, v);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int base, input int npix);
        for (int i = 0; i < npix; i++) send(base + i);
    endtask

    task automatic drain();
        int n = 0;
        pix_valid = 1'b0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", q.size());
            q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic stall_window2();
        int base = hs_count;
        int n = 0;
        while (hs_count < base + 1 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        win_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (win_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 3; k++) begin
            chk("stall_valid", 32'(win_valid), 32'd1);
            chk("stall_win", 32'({win_tl, win_tr, win_bl, win_br}), 32'({5'd2, 5'd3, 5'd6, 5'd7}));
            chk("stall_pix_ready", 32'(pix_ready), 32'd0);
            if (k < 2) @(negedge clk);
        end
        @(posedge clk);
        #1;
        win_ready = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_win_valid", 32'(win_valid), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_win", 32'({win_tl, win_tr, win_bl, win_br}), 32'd0);
        chk("rst_pix_ready", 32'(pix_ready), 32'd1);
        rst_n = 1'b1;

        // 1: plain frame
        push_frame(0, 4);
        send_frame(0, 16);
        drain();
        chk("t1_frames", 32'(fd_count), 32'd1);

        // 2: backpressure on the second window
        push_frame(0, 4);
        fork
            stall_window2();
        join_none
        send_frame(0, 16);
        drain();
        chk("t2_frames", 32'(fd_count), 32'd2);

        // 3: reset mid-frame after pixel 9, then a clean frame
        push_frame(0, 2);
        send_frame(0, 10);
        drain();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t3_rst_win_valid", 32'(win_valid), 32'd0);
        chk("t3_rst_frame_done", 32'(frame_done), 32'd0);
        chk("t3_rst_pix_ready", 32'(pix_ready), 32'd1);
        rst_n = 1'b1;
        push_frame(0, 4);
        send_frame(0, 16);
        drain();
        chk("t3_frames", 32'(fd_count), 32'd3);

        // 4: two frames back-to-back with pix_valid held high
        push_frame(0, 4);
        push_frame(16, 4);
        send_frame(0, 32);
        drain();
        chk("t4_frames", 32'(fd_count), 32'd5);

        // 5: all-max pixels with random input gaps
        for (int k = 0; k < 4; k++) push_win(31, 31, 31, 31, (k == 3), k[1], k[0]);
        for (int i = 0; i < 16; i++) begin
            send(31);
            if ($urandom_range(0, 2) == 0) begin
                pix_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain();
        chk("t5_frames", 32'(fd_count), 32'd6);
        chk("t5_windows", 32'(hs_count), 32'd26);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
